// File: rtl/apb_pkg.sv
// Shared APB definitions: bus state encoding and default widths.
// Used by the APB requester and by the slave-side blocks.
package apb_pkg;

  localparam int APB_DATA_WIDTH     = 32;
  localparam int APB_ADDR_WIDTH     = 8;
  localparam int APB_TIMEOUT_CYCLES = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } apb_state_t;

endpackage

// File: rtl/apb_master_if.sv
// Command/response and APB bus signals of the APB requester.
// master modport: the requester's view; slave modport: the view of whatever
// sits on the other side (command source, APB peripheral model).
interface apb_master_if
  import apb_pkg::*;
#(
  parameter int DATA_WIDTH = APB_DATA_WIDTH,
  parameter int ADDR_WIDTH = APB_ADDR_WIDTH
) ();

  // command side
  logic                  cmd_valid;
  logic                  cmd_ready;
  logic                  cmd_write;
  logic [ADDR_WIDTH-1:0] cmd_addr;
  logic [DATA_WIDTH-1:0] cmd_wdata;

  // response side
  logic                  rsp_valid;
  logic [DATA_WIDTH-1:0] rsp_rdata;
  logic                  rsp_err;

  // APB bus
  logic                  psel;
  logic                  penable;
  logic                  pwrite;
  logic [ADDR_WIDTH-1:0] paddr;
  logic [DATA_WIDTH-1:0] pwdata;
  logic [DATA_WIDTH-1:0] prdata;
  logic                  pready;
  logic                  pslverr;

  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_wdata,
    output cmd_ready,
    output rsp_valid, rsp_rdata, rsp_err,
    output psel, penable, pwrite, paddr, pwdata,
    input  prdata, pready, pslverr
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_wdata,
    input  cmd_ready,
    input  rsp_valid, rsp_rdata, rsp_err,
    input  psel, penable, pwrite, paddr, pwdata,
    output prdata, pready, pslverr
  );

endinterface

// File: rtl/apb_wait_timer.sv
// Saturating wait-state counter for the APB requester.
// expired is high once LIMIT-1 increments have been counted, so a caller that
// checks it together with the current inc sees the LIMIT-th waiting cycle.
module apb_wait_timer #(
  parameter int LIMIT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic inc,
  output logic expired
);

  localparam int CW = $clog2(LIMIT + 1);
  localparam logic [CW-1:0] CNT_MAX  = CW'(LIMIT);
  localparam logic [CW-1:0] CNT_LAST = CW'(LIMIT - 1);

  logic [CW-1:0] cnt_q;

  // count consecutive waiting cycles, holding at LIMIT
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (clr) begin
      cnt_q <= '0;
    end else if (inc && (cnt_q != CNT_MAX)) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign expired = (cnt_q >= CNT_LAST);

endmodule

// File: rtl/apb_master.sv
// APB requester: turns valid/ready commands into APB SETUP/ACCESS transfers
// and returns a one-cycle response pulse with read data and error status.
// Optional: define APB_MASTER_TIMEOUT_EN to abort an ACCESS phase after
// TIMEOUT_CYCLES consecutive cycles without pready.
module apb_master
  import apb_pkg::*;
#(
  parameter int DATA_WIDTH     = APB_DATA_WIDTH,
  parameter int ADDR_WIDTH     = APB_ADDR_WIDTH,
  parameter int TIMEOUT_CYCLES = APB_TIMEOUT_CYCLES
) (
  input  logic         pclk,
  input  logic         preset,
  apb_master_if.master bus
);

  apb_state_t            state_q, state_d;
  logic                  complete;
  logic                  accept;
  logic                  abort;

  logic                  psel_q, penable_q, pwrite_q;
  logic [ADDR_WIDTH-1:0] paddr_q;
  logic [DATA_WIDTH-1:0] pwdata_q;
  logic                  rsp_valid_q, rsp_err_q;
  logic [DATA_WIDTH-1:0] rsp_rdata_q;

  assign complete      = (state_q == ACCESS) && bus.pready;
  // a new command can be taken while the current one finishes, keeping psel high
  assign bus.cmd_ready = (state_q == IDLE) || complete;
  assign accept        = bus.cmd_valid && bus.cmd_ready;

`ifdef APB_MASTER_TIMEOUT_EN
  logic expired;

  apb_wait_timer #(
    .LIMIT (TIMEOUT_CYCLES)
  ) u_wait_timer (
    .clk     (pclk),
    .rst     (preset),
    .clr     (state_q == SETUP),
    .inc     ((state_q == ACCESS) && !bus.pready),
    .expired (expired)
  );

  // abort only happens while pready is low, so cmd_ready is low that cycle
  assign abort = (state_q == ACCESS) && !bus.pready && expired;
`else
  // without the timer ACCESS waits for pready indefinitely
  assign abort = 1'b0 && (TIMEOUT_CYCLES > 0);
`endif

  // next-state selection for the IDLE/SETUP/ACCESS sequencer
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = SETUP;
      SETUP:   state_d = ACCESS;
      ACCESS: begin
        if (abort)         state_d = IDLE;
        else if (complete) state_d = accept ? SETUP : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // state register plus registered psel/penable decoded from the next state
  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      state_q   <= IDLE;
      psel_q    <= 1'b0;
      penable_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      psel_q    <= (state_d != IDLE);
      penable_q <= (state_d == ACCESS);
    end
  end

  // capture the command on accept; held stable through the whole transfer
  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      pwrite_q <= 1'b0;
      paddr_q  <= '0;
      pwdata_q <= '0;
    end else if (accept) begin
      pwrite_q <= bus.cmd_write;
      paddr_q  <= bus.cmd_addr;
      pwdata_q <= bus.cmd_write ? bus.cmd_wdata : '0;
    end
  end

  // one-cycle response on completion or timeout abort
  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      rsp_valid_q <= complete || abort;
      if (complete) begin
        rsp_err_q   <= bus.pslverr;
        rsp_rdata_q <= pwrite_q ? '0 : bus.prdata;
      end else if (abort) begin
        rsp_err_q   <= 1'b1;
        rsp_rdata_q <= '0;
      end
    end
  end

  assign bus.psel      = psel_q;
  assign bus.penable   = penable_q;
  assign bus.pwrite    = pwrite_q;
  assign bus.paddr     = paddr_q;
  assign bus.pwdata    = pwdata_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_err   = rsp_err_q;
  assign bus.rsp_rdata = rsp_rdata_q;

endmodule
